// File: rtl/smg_scan.sv
// ---------------------------------------------------------------------------
// smg_scan - time-multiplexed 4-digit seven-segment scan driver
//
// Scans four digits, one digit per slot of SCAN_DIV clocks. Each slot starts
// with BLANK_CYC clocks where every digit is off, which prevents ghosting.
// The displayed value is double-buffered. A write that arrives while the
// scan is running is parked in a pending register. That register is promoted
// only at a frame boundary, so one frame never mixes old and new digits.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   en          scan enable; 0 turns the display off and parks the scanner
//   value_we    single-cycle load strobe for value_in / dp_in
//   value_in    four hex digits, [3:0] is digit 0 (rightmost)
//   dp_in       decimal point per digit, bit k belongs to digit k
//   blank_lz    leading-zero blanking enable
//   smg         {sel[3:0], seg[7:0]}, seg = {dp,g,f,e,d,c,b,a}; registered
//   frame_start one-cycle pulse on the first cycle of each digit-0 slot
// ---------------------------------------------------------------------------
module smg_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        value_we,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [11:0] smg,
  output logic        frame_start
);

  localparam int PS_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  // The "off" pattern for each group. An active-high pattern XORed with this
  // mask produces the pin-level value for either polarity.
  localparam logic [3:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? 4'hF  : 4'h0;
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  localparam logic [PS_W-1:0] PS_BLANK_END = PS_W'(BLANK_CYC - 1);
  localparam logic [PS_W-1:0] PS_SLOT_END  = PS_W'(SCAN_DIV - 1);

  // Hex to active-high gfedcba.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  logic [1:0]      state_q, state_d;
  logic [1:0]      digit_q, digit_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [15:0]     disp_val_q, disp_val_d;
  logic [3:0]      disp_dp_q, disp_dp_d;
  logic [15:0]     pend_val_q, pend_val_d;
  logic [3:0]      pend_dp_q, pend_dp_d;
  logic            pend_valid_q, pend_valid_d;
  logic [11:0]     smg_q, smg_d;
  logic            fs_q, fs_d;
  logic            boundary;

  // Scan sequencing and buffering.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    presc_d      = presc_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    fs_d         = 1'b0;
    boundary     = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      digit_d = 2'd0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_BLANK;
          digit_d  = 2'd0;
          presc_d  = '0;
          fs_d     = 1'b1;
          boundary = 1'b1;
        end
        S_BLANK: begin
          presc_d = presc_q + 1'b1;
          if (presc_q == PS_BLANK_END) state_d = S_DRIVE;
        end
        S_DRIVE: begin
          if (presc_q == PS_SLOT_END) begin
            presc_d = '0;
            digit_d = digit_q + 2'd1;
            state_d = S_BLANK;
            if (digit_q == 2'd3) begin
              fs_d     = 1'b1;
              boundary = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          digit_d = 2'd0;
          presc_d = '0;
        end
      endcase
    end

    // Promotion reads the old pend. A write on the same cycle therefore lands
    // in pend afterwards and keeps pend_valid set.
    if (boundary && pend_valid_q) begin
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (value_we) begin
      if (state_q == S_IDLE) begin
        disp_val_d   = value_in;
        disp_dp_d    = dp_in;
        pend_valid_d = 1'b0;
      end else begin
        pend_val_d   = value_in;
        pend_dp_d    = dp_in;
        pend_valid_d = 1'b1;
      end
    end
  end

  // Output pattern for the state being entered. The output is registered
  // alongside the state, so smg always matches the current slot.
  // disp cannot change on an edge that enters DRIVE, so disp_q is safe here.
  logic [3:0] nib;
  logic       z1, z2, z3;
  logic       lz_blank;
  logic [7:0] seg_on;
  logic [3:0] sel_on;

  always_comb begin
    z3 = (disp_val_q[15:12] == 4'h0);
    z2 = z3 && (disp_val_q[11:8] == 4'h0);
    z1 = z2 && (disp_val_q[7:4] == 4'h0);

    case (digit_d)
      2'd0: begin nib = disp_val_q[3:0];   lz_blank = 1'b0;          end
      2'd1: begin nib = disp_val_q[7:4];   lz_blank = blank_lz & z1; end
      2'd2: begin nib = disp_val_q[11:8];  lz_blank = blank_lz & z2; end
      default: begin nib = disp_val_q[15:12]; lz_blank = blank_lz & z3; end
    endcase

    seg_on      = {disp_dp_q[digit_d], seg_decode(nib)};
    if (lz_blank) seg_on[6:0] = 7'h00;
    sel_on      = 4'b0001 << digit_d;

    if (state_d == S_DRIVE) smg_d = {sel_on ^ SEL_OFF, seg_on ^ SEG_OFF};
    else                    smg_d = {SEL_OFF, SEG_OFF};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      digit_q      <= 2'd0;
      presc_q      <= '0;
      disp_val_q   <= 16'h0000;
      disp_dp_q    <= 4'h0;
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_valid_q <= 1'b0;
      smg_q        <= {SEL_OFF, SEG_OFF};
      fs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      presc_q      <= presc_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      smg_q        <= smg_d;
      fs_q         <= fs_d;
    end
  end

  assign smg         = smg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_smg_scan.sv
// ---------------------------------------------------------------------------
// tb_smg_scan - directed testbench for smg_scan (SCAN_DIV=8, BLANK_CYC=2,
// both polarities active-low). A frame is 32 cycles: each digit slot has
// 2 blank cycles followed by 6 drive cycles. Inputs change on the falling
// edge, and outputs are sampled on the falling edge before inputs change.
// ---------------------------------------------------------------------------
module tb_smg_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        value_we;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [11:0] smg;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  smg_scan #(
    .SCAN_DIV(8),
    .BLANK_CYC(2),
    .SEL_ACTIVE_LOW(1),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .value_we(value_we),
    .value_in(value_in),
    .dp_in(dp_in),
    .blank_lz(blank_lz),
    .smg(smg),
    .frame_start(frame_start)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Park in IDLE, load disp directly, then enable. Returns at the sample
  // point of frame cycle 0, which is the digit-0 BLANK cycle with frame_start.
  task automatic restart(input logic [15:0] v, input logic [3:0] d);
    en = 1'b0;
    tick();
    value_we = 1'b1; value_in = v; dp_in = d;
    tick();
    value_we = 1'b0; en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (smg !== 12'hFFF) begin n_fail++; $display("FAIL reset_smg: got %h want fff", smg); end
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (smg !== 12'hFFF) begin n_fail++; $display("FAIL idle_smg[%0d]: got %h want fff", i, smg); end
    end
  endtask

  task automatic test_scan();
    logic [11:0] exp_slot [4];
    logic [11:0] exp;
    exp_slot[0] = 12'hE99; exp_slot[1] = 12'hDB0;
    exp_slot[2] = 12'hBA4; exp_slot[3] = 12'h7F9;
    restart(16'h1234, 4'h0);
    for (int c = 0; c <= 32; c++) begin
      if (c > 0) tick();
      exp = ((c % 8) < 2) ? 12'hFFF : exp_slot[(c / 8) % 4];
      n_checks++;
      if (smg !== exp) begin n_fail++; $display("FAIL scan_smg c=%0d: got %h want %h", c, smg, exp); end
      n_checks++;
      if (frame_start !== ((c % 32) == 0)) begin
        n_fail++; $display("FAIL scan_fs c=%0d: got %b want %b", c, frame_start, (c % 32) == 0);
      end
    end
  endtask

  task automatic test_mid_frame_update();
    logic [11:0] exp_tab [2][4];
    logic [11:0] exp;
    exp_tab[0][0] = 12'hE99; exp_tab[0][1] = 12'hDB0; exp_tab[0][2] = 12'hBA4; exp_tab[0][3] = 12'h7F9;
    exp_tab[1][0] = 12'hE92; exp_tab[1][1] = 12'hDC0; exp_tab[1][2] = 12'hBC0; exp_tab[1][3] = 12'h7C0;
    restart(16'h1234, 4'h0);
    for (int c = 1; c < 64; c++) begin
      tick();
      value_we = 1'b0;
      if ((c % 8) >= 2) begin
        exp = exp_tab[c / 32][(c / 8) % 4];
        n_checks++;
        if (smg !== exp) begin n_fail++; $display("FAIL midupd_smg c=%0d: got %h want %h", c, smg, exp); end
      end
      if (c == 10) begin value_we = 1'b1; value_in = 16'h0005; dp_in = 4'h0; end
    end
  endtask

  task automatic test_leading_zero();
    logic [11:0] exp_tab [2][4];
    logic [11:0] exp;
    exp_tab[0][0] = 12'hE92; exp_tab[0][1] = 12'hD7F; exp_tab[0][2] = 12'hBFF; exp_tab[0][3] = 12'h7FF;
    exp_tab[1][0] = 12'hEC0; exp_tab[1][1] = 12'hDFF; exp_tab[1][2] = 12'hBFF; exp_tab[1][3] = 12'h7FF;
    blank_lz = 1'b1;
    restart(16'h0005, 4'b0010);
    for (int c = 1; c < 64; c++) begin
      tick();
      value_we = 1'b0;
      if ((c % 8) >= 2) begin
        exp = exp_tab[c / 32][(c / 8) % 4];
        n_checks++;
        if (smg !== exp) begin n_fail++; $display("FAIL lz_smg c=%0d: got %h want %h", c, smg, exp); end
      end
      if (c == 5) begin value_we = 1'b1; value_in = 16'h0000; dp_in = 4'h0; end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_boundary_write();
    logic [11:0] exp_tab [2][2];
    logic [11:0] exp;
    exp_tab[0][0] = 12'hE88; exp_tab[0][1] = 12'hD88;
    exp_tab[1][0] = 12'hE83; exp_tab[1][1] = 12'hD83;
    restart(16'h0000, 4'h0);
    for (int c = 1; c < 96; c++) begin
      tick();
      value_we = 1'b0;
      if (c >= 32 && (c % 8) >= 2 && ((c / 8) % 4) < 2) begin
        exp = exp_tab[(c / 32) - 1][(c / 8) % 4];
        n_checks++;
        if (smg !== exp) begin n_fail++; $display("FAIL bnd_smg c=%0d: got %h want %h", c, smg, exp); end
      end
      if (c == 32 || c == 64) begin
        n_checks++;
        if (frame_start !== 1'b1) begin n_fail++; $display("FAIL bnd_fs c=%0d: got %b want 1", c, frame_start); end
      end
      if (c == 5)  begin value_we = 1'b1; value_in = 16'h00AA; dp_in = 4'h0; end
      if (c == 31) begin value_we = 1'b1; value_in = 16'h00BB; dp_in = 4'h0; end
    end
  endtask

  task automatic test_en_drop();
    restart(16'h1234, 4'h0);
    for (int c = 1; c <= 18; c++) tick();
    n_checks++;
    if (smg !== 12'hBA4) begin n_fail++; $display("FAIL endrop_pre: got %h want ba4", smg); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (smg !== 12'hFFF) begin n_fail++; $display("FAIL endrop_off[%0d]: got %h want fff", i, smg); end
      n_checks++;
      if (frame_start !== 1'b0) begin n_fail++; $display("FAIL endrop_fs[%0d]: got %b want 0", i, frame_start); end
    end
    en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (smg !== ((c < 2) ? 12'hFFF : 12'hE99)) begin
        n_fail++; $display("FAIL enrise_smg c=%0d: got %h want %h", c, smg, (c < 2) ? 12'hFFF : 12'hE99);
      end
      n_checks++;
      if (frame_start !== (c == 0)) begin n_fail++; $display("FAIL enrise_fs c=%0d: got %b want %b", c, frame_start, c == 0); end
    end
  endtask

  task automatic test_reset_async();
    // Assert reset while frame_start is high, with no clock edge.
    restart(16'h1234, 4'h0);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL areset_fs: got %b want 0", frame_start); end
    tick();
    reset = 1'b0;
    // Assert reset mid-DRIVE of digit 0, with no clock edge.
    restart(16'h1234, 4'h0);
    for (int c = 1; c <= 4; c++) tick();
    n_checks++;
    if (smg !== 12'hE99) begin n_fail++; $display("FAIL areset_pre: got %h want e99", smg); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (smg !== 12'hFFF) begin n_fail++; $display("FAIL areset_smg: got %h want fff", smg); end
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL areset_fs2: got %b want 0", frame_start); end
    en = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (smg !== 12'hFFF) begin n_fail++; $display("FAIL areset_idle[%0d]: got %h want fff", i, smg); end
    end
    // After reset disp is zero, so enabling shows "0" on digit 0.
    en = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    n_checks++;
    if (smg !== 12'hEC0) begin n_fail++; $display("FAIL areset_disp0: got %h want ec0", smg); end
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    value_we = 1'b0;
    value_in = 16'h0000;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    test_reset();
    test_scan();
    test_mid_frame_update();
    test_leading_zero();
    test_boundary_write();
    test_en_drop();
    test_reset_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
